// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one partial product per clock, valid/ready on both sides.
// Optional early termination when the remaining multiplier bits are all zero: define SEQ_MULT_EARLY_TERM_EN.
module seq_multiplier #(
   parameter int WIDTH = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [PW-1:0]     mcand;
   logic [PW-1:0]     acc;
   logic [PW-1:0]     acc_sum;
   logic [WIDTH-1:0]  mplier;
   logic [CW-1:0]     cnt;
   logic              accept;
   logic              calc_done;

   assign accept  = in_valid && in_ready;
   assign acc_sum = mplier[0] ? (acc + mcand) : acc;

   // With early termination, an exhausted multiplier ends the pass; acc_sum equals acc then.
`ifdef SEQ_MULT_EARLY_TERM_EN
   assign calc_done = (cnt == LAST) || (mplier == '0);
`else
   assign calc_done = (cnt == LAST);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (accept) begin
               state_nxt = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (calc_done) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy = 1'b1;
            if (out_valid && out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // The final add lands in p directly, so the product is ready the same edge CALC ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         cnt       <= '0;
         p         <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand  <= {{WIDTH{1'b0}}, a};
                  mplier <= b;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            CALC: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (calc_done) begin
                  p         <= acc_sum;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a WIDTH=3 and a WIDTH=8 instance sharing clock and reset.
module tb_seq_multiplier;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   logic       iv3, ir3, ov3, or3, busy3;
   logic [2:0] a3, b3;
   logic [5:0] p3;

   logic        iv8, ir8, ov8, or8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   int total = 0;
   int bad   = 0;

   logic [15:0] q3[$];
   logic [15:0] q8[$];

   seq_multiplier #(.WIDTH(3)) u_mul3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
      .out_valid(ov3), .out_ready(or3), .p(p3), .busy(busy3)
   );

   seq_multiplier #(.WIDTH(8)) u_mul8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
      .out_valid(ov8), .out_ready(or8), .p(p8), .busy(busy8)
   );

   function automatic int exp_lat8(input logic [7:0] bv);
`ifdef SEQ_MULT_EARLY_TERM_EN
      int m;
      m = -1;
      for (int i = 0; i < 8; i++) begin
         if (bv[i]) m = i;
      end
      if (m < 0) return 1;
      return (m + 2 < 8) ? (m + 2) : 8;
`else
      return (bv === 8'hxx) ? 0 : 8;
`endif
   endfunction

   // Drives one WIDTH=8 operation; lat is clocks from accept edge to first out_valid, -1 on timeout.
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, output int lat,
                      output logic [15:0] expv, output logic [15:0] got);
      int w;
      w = 0;
      @(negedge clk);
      while (!ir8 && w < 50) begin
         @(negedge clk);
         w++;
      end
      a8 = av;
      b8 = bv;
      iv8 = 1'b1;
      q8.push_back(16'(av) * 16'(bv));
      lat = -1;
      got = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         iv8 = 1'b0;
         if (ov8) begin
            lat = c - 1;
            got = p8;
            break;
         end
      end
      expv = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
      if (or8 && lat > 0) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      iv3 = 1'b0; or3 = 1'b0; a3 = '0; b3 = '0;
      iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
      repeat (2) @(negedge clk);
      total++; if (ov3 !== 1'b0)   begin bad++; $display("[TB] FAIL rst_ov3 got=%b exp=0", ov3); end
      total++; if (p3 !== 6'd0)    begin bad++; $display("[TB] FAIL rst_p3 got=%0d exp=0", p3); end
      total++; if (ir3 !== 1'b1)   begin bad++; $display("[TB] FAIL rst_ir3 got=%b exp=1", ir3); end
      total++; if (busy3 !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy3 got=%b exp=0", busy3); end
      total++; if (ov8 !== 1'b0)   begin bad++; $display("[TB] FAIL rst_ov8 got=%b exp=0", ov8); end
      total++; if (p8 !== 16'd0)   begin bad++; $display("[TB] FAIL rst_p8 got=%0d exp=0", p8); end
      total++; if (ir8 !== 1'b1)   begin bad++; $display("[TB] FAIL rst_ir8 got=%b exp=1", ir8); end
      total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy8 got=%b exp=0", busy8); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic3;
      int lat, vcyc, low;
      logic [15:0] expv, got;
      lat = -1; vcyc = 0; low = 0; got = '0;
      @(negedge clk);
      a3 = 3'd7; b3 = 3'd2; iv3 = 1'b1; or3 = 1'b1;
      q3.push_back(16'd7 * 16'd2);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         iv3 = 1'b0;
         if (!ir3) low++;
         if (ov3) begin
            if (lat < 0) begin
               lat = c - 1;
               got = {10'd0, p3};
            end
            vcyc++;
         end
      end
      expv = (q3.size() > 0) ? q3.pop_front() : 16'hxxxx;
      total++; if (got !== expv) begin bad++; $display("[TB] FAIL basic3_p got=%0d exp=%0d", got, expv); end
      total++; if (lat != 3)     begin bad++; $display("[TB] FAIL basic3_lat got=%0d exp=3", lat); end
      total++; if (vcyc != 1)    begin bad++; $display("[TB] FAIL basic3_vcyc got=%0d exp=1", vcyc); end
      total++; if (low != 4)     begin bad++; $display("[TB] FAIL basic3_notready got=%0d exp=4", low); end
      total++; if (p3 !== 6'd14) begin bad++; $display("[TB] FAIL basic3_p_kept got=%0d exp=14", p3); end
   endtask

   task automatic test_exhaustive3;
      int idx, last, cyc;
      logic [15:0] expv;
      idx = 0; last = 0; cyc = 0;
      or3 = 1'b1;
      while ((idx < 64 || q3.size() > 0) && cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (ov3) begin
            expv = (q3.size() > 0) ? q3.pop_front() : 16'hxxxx;
            total++;
            if ({10'd0, p3} !== expv) begin
               bad++;
               $display("[TB] FAIL exh3_p got=%0d exp=%0d", p3, expv);
            end
         end
         if (ir3 && idx < 64) begin
            a3 = 3'(idx >> 3);
            b3 = 3'(idx & 7);
            iv3 = 1'b1;
            q3.push_back(16'(a3) * 16'(b3));
            if (idx > 0) begin
               total++;
               if (cyc - last != 5) begin
                  bad++;
                  $display("[TB] FAIL exh3_interval got=%0d exp=5", cyc - last);
               end
            end
            last = cyc;
            idx++;
         end else begin
            iv3 = 1'b0;
         end
      end
      iv3 = 1'b0;
      total++;
      if (cyc >= 500) begin
         bad++;
         $display("[TB] FAIL exh3_timeout got=%0d exp<500", cyc);
      end
   endtask

   task automatic test_hold8;
      int lat;
      logic [15:0] expv, got;
      or8 = 1'b0;
      op8(8'd255, 8'd255, lat, expv, got);
      total++; if (got !== expv) begin bad++; $display("[TB] FAIL hold8_p got=%0d exp=%0d", got, expv); end
      total++; if (expv !== 16'd65025) begin bad++; $display("[TB] FAIL hold8_model got=%0d exp=65025", expv); end
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         total++;
         if (ov8 !== 1'b1 || p8 !== 16'd65025 || ir8 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hold8_stable got=ov%b/p%0d/ir%b exp=ov1/p65025/ir0", ov8, p8, ir8);
         end
      end
      or8 = 1'b1;
      @(negedge clk);
      total++; if (ir8 !== 1'b1) begin bad++; $display("[TB] FAIL hold8_ready got=%b exp=1", ir8); end
      total++; if (ov8 !== 1'b0) begin bad++; $display("[TB] FAIL hold8_ovclr got=%b exp=0", ov8); end
      total++; if (p8 !== 16'd65025) begin bad++; $display("[TB] FAIL hold8_pkeep got=%0d exp=65025", p8); end
   endtask

   task automatic test_abort8;
      int lat;
      logic [15:0] expv, got;
      or8 = 1'b1;
      @(negedge clk);
      a8 = 8'd200; b8 = 8'd100; iv8 = 1'b1;
      q8.push_back(16'd200 * 16'd100);
      @(negedge clk);
      iv8 = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (busy8 !== 1'b1) begin bad++; $display("[TB] FAIL abort8_busy_pre got=%b exp=1", busy8); end
      #1 rst_n = 1'b0;
      #1;
      q8.delete();
      total++; if (ov8 !== 1'b0)   begin bad++; $display("[TB] FAIL abort8_ov got=%b exp=0", ov8); end
      total++; if (p8 !== 16'd0)   begin bad++; $display("[TB] FAIL abort8_p got=%0d exp=0", p8); end
      total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL abort8_busy got=%b exp=0", busy8); end
      total++; if (ir8 !== 1'b1)   begin bad++; $display("[TB] FAIL abort8_ready got=%b exp=1", ir8); end
      @(negedge clk);
      rst_n = 1'b1;
      op8(8'd12, 8'd13, lat, expv, got);
      total++; if (got !== expv) begin bad++; $display("[TB] FAIL abort8_next_p got=%0d exp=%0d", got, expv); end
      total++; if (lat != exp_lat8(8'd13)) begin bad++; $display("[TB] FAIL abort8_next_lat got=%0d exp=%0d", lat, exp_lat8(8'd13)); end
   endtask

   task automatic test_early_term8;
      int lat;
      logic [15:0] expv, got;
      logic [7:0] av[3];
      logic [7:0] bv[3];
      av[0] = 8'd99; bv[0] = 8'd0;
      av[1] = 8'd99; bv[1] = 8'd1;
      av[2] = 8'd2;  bv[2] = 8'h80;
      or8 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         op8(av[i], bv[i], lat, expv, got);
         total++;
         if (got !== expv) begin
            bad++;
            $display("[TB] FAIL early_p%0d got=%0d exp=%0d", i, got, expv);
         end
         total++;
         if (lat != exp_lat8(bv[i])) begin
            bad++;
            $display("[TB] FAIL early_lat%0d got=%0d exp=%0d", i, lat, exp_lat8(bv[i]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic3();
      test_exhaustive3();
      test_hold8();
      test_abort8();
      test_early_term8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised unsigned sequential shift-add multiplier. It is the next generation of the team's fixed 3-bit combinational multiplier.
- Takes two WIDTH-bit operands through a valid/ready input handshake and computes one partial product per clock.
- Presents the 2*WIDTH-bit product through a valid/ready output handshake.
- Used wherever a multiplier is needed and area matters more than throughput.

Parameters:
- WIDTH, 3, operand width in bits; legal range 2..32. Product width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands a/b are valid this cycle.
- in_ready  output  1  block can accept operands; combinational, equals (state==IDLE).
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  p holds a completed product; registered.
- out_ready  input  1  consumer accepts p this cycle.
- p  output  2*WIDTH  product a*b; registered.
- busy  output  1  high in CALC or DONE; combinational from state.

Behaviour:
- The design has one clock. Reset is asynchronous and active-low.
- While rst_n is low: state=IDLE, out_valid=0, p=0, internal accumulator, shift registers and counter=0. As a result, in_ready=1 and busy=0.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on the edge where in_valid&&in_ready. On that edge:
  - mcand <= zero-extended a (2*WIDTH bits)
  - mplier <= b
  - acc <= 0
  - cnt <= 0
- a/b are ignored in every other cycle. in_valid in CALC/DONE is held off by in_ready=0 and is not an error.
- CALC, each cycle:
  - if mplier[0], acc <= acc + mcand (2*WIDTH-bit add, no overflow possible)
  - mcand <= mcand<<1
  - mplier <= mplier>>1
  - cnt <= cnt+1
- CALC -> DONE on the edge where cnt==WIDTH-1, i.e. after exactly WIDTH CALC cycles. On that edge:
  - p <= final acc, including the last cycle's add
  - out_valid <= 1
- Latency: the first cycle with out_valid=1 is WIDTH clocks after the accept edge.
- DONE: p and out_valid are held stable until out_valid&&out_ready.
  - On that edge: state -> IDLE, out_valid <= 0.
  - p keeps its value until the next DONE entry.
- No back-to-back overlap: a new operand is accepted at the earliest in the cycle after the output handshake. Minimum issue interval is WIDTH+2 cycles when out_ready is held high.
- Boundary cases:
  - a=0 or b=0 gives p=0 at normal latency.
  - Max operands give (2^WIDTH-1)^2 with no truncation.
- Reset asserted mid-CALC or in DONE aborts the operation immediately and asynchronously. The result is discarded, and all outputs return to reset values.
- out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: in CALC, if mplier==0 at the start of a cycle, that cycle performs no add and the block transitions to DONE with p <= acc and out_valid <= 1.
  - Latency = min(WIDTH, m+2), where m is the index of the highest set bit of b.
  - Latency is 1 when b=0.
  - The cnt==WIDTH-1 exit still applies.
- Not defined: latency is always exactly WIDTH; no mplier==0 check exists.
- The product value is identical in both builds.

Test Plan:
- WIDTH=3, a=3'b111, b=3'b010, out_ready=1 -> p=6'b001110 (14); out_valid high 3 cycles after accept for 1 cycle; in_ready low for 4 cycles.
- WIDTH=3, exhaustive a,b in 0..7 back-to-back with out_ready=1 -> every p equals a*b (e.g. 7*7=49); issue interval is 5 cycles.
- WIDTH=8, a=255, b=255, out_ready held 0 for 10 cycles after out_valid -> p=65025 stable and out_valid held the whole time; in_ready=0 until the cycle after out_ready is raised.
- WIDTH=8, a=200, b=100, rst_n pulled low 4 cycles after accept -> out_valid, p and busy go 0 immediately. After release, in_ready=1, and a new 12*13 gives p=156 with no trace of the aborted operation.
- WIDTH=8, SEQ_MULT_EARLY_TERM_EN defined:
  - b=0, a=99 -> p=0, latency 1.
  - b=1, a=99 -> p=99, latency 2.
  - b=8'h80, a=2 -> p=256, latency 8.
  - Without the macro, all three cases have latency 8.
